// File: rtl/soc_system_sprite_line_fetch_if.sv
// Sprite ROM read bus.
//   rom_address    word address presented to the ROM
//   rom_chipselect ROM select, high while a line fetch is running
//   rom_clken      ROM clock enable, high while a line fetch is running
//   rom_readdata   ROM word, valid one cycle after its address
// The fetcher is the master (drives address/strobes); the ROM is the slave.
// There is no backpressure: every cycle with rom_clken high is a read whose
// data is taken unconditionally on the following cycle.
interface soc_system_sprite_line_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rom_address;
  logic              rom_chipselect;
  logic              rom_clken;
  logic [DATA_W-1:0] rom_readdata;

  modport master (
    output rom_address,
    output rom_chipselect,
    output rom_clken,
    input  rom_readdata
  );

  modport slave (
    input  rom_address,
    input  rom_chipselect,
    input  rom_clken,
    output rom_readdata
  );
endinterface

// File: rtl/soc_system_sprite_line_fetch.sv
// Sprite line fetcher and pixel source.
// On each line_start it decides whether the coming scanline crosses the
// sprite and, if so, copies that sprite row from ROM into a line buffer
// (SPR_W fetch cycles plus one drain cycle). During active video it
// returns the buffered pixel for hcount, one cycle later, with
// colour-key transparency.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enable                sprite enable, sampled at line_start
//   line_start            1-cycle pulse at start of hblank
//   next_line             line about to be displayed (valid with line_start)
//   sprite_x, sprite_y    sprite position, sampled at line_start
//   hcount                current active-video column
//   rom                   ROM read bus (master side)
//   pix_valid, pix_data   opaque sprite pixel (data 0 when not valid)
//   busy                  fetch in progress
//   dbg_state             FSM state (IDLE/FETCH/DRAIN)
//   dbg_line_valid        line buffer holds a complete row for this line
module soc_system_sprite_line_fetch #(
  parameter int          SPR_W     = 32,
  parameter int          SPR_H     = 32,
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        line_start,
  input  logic [9:0]  next_line,
  input  logic [10:0] sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [10:0] hcount,
  soc_system_sprite_line_fetch_if.master rom,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic        dbg_line_valid
);

  localparam int IDX_W = $clog2(SPR_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] row_q;
  logic [10:0]       x_q;
  logic              line_valid;
  logic [15:0]       line_buf [SPR_W];

  // Row within the sprite; a negative result (sprite below this line)
  // shows up as bit 10 set.
  logic [10:0] row;
  logic        row_hit;
  logic        start_fetch;

  assign row         = {1'b0, next_line} - {1'b0, sprite_y};
  assign row_hit     = !row[10] && (row < 11'(SPR_H));
  assign start_fetch = enable && row_hit;

  // A line_start always wins, including mid-fetch: the old fetch is
  // abandoned and the new line is evaluated exactly as from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      row_q      <= '0;
      x_q        <= '0;
      line_valid <= 1'b0;
    end else if (line_start) begin
      x_q        <= sprite_x;
      row_q      <= ADDR_W'(row);
      line_valid <= 1'b0;
      idx        <= '0;
      state      <= start_fetch ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH: begin
          idx <= idx + 1'b1;
          if (idx == IDX_W'(SPR_W - 1)) state <= DRAIN;
        end
        DRAIN: begin
          line_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM data lags its address by one cycle, so the word arriving while
  // idx is presented belongs to column idx-1; DRAIN catches the last one.
  logic             buf_we;
  logic [IDX_W-1:0] buf_wa;

  always_comb begin
    buf_we = 1'b0;
    buf_wa = '0;
    if (state == FETCH && idx != '0) begin
      buf_we = 1'b1;
      buf_wa = idx - 1'b1;
    end else if (state == DRAIN) begin
      buf_we = 1'b1;
      buf_wa = IDX_W'(SPR_W - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) line_buf[buf_wa] <= rom.rom_readdata;
  end

  // Strobes decode straight from state so an asynchronous reset drops
  // them immediately.
  assign busy               = (state != IDLE);
  assign rom.rom_chipselect = (state == FETCH);
  assign rom.rom_clken      = (state == FETCH);
  assign rom.rom_address    = (state == FETCH) ? ((row_q << IDX_W) | ADDR_W'(idx)) : '0;

  // Pixel path: column offset into the sprite; negative means left of it.
  logic [11:0] off;
  logic        off_hit;
  logic [15:0] buf_px;

  assign off     = {1'b0, hcount} - {1'b0, x_q};
  assign off_hit = !off[11] && (off < 12'(SPR_W));
  assign buf_px  = line_buf[off[IDX_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else if (line_valid && !busy && off_hit && buf_px != KEY_COLOR) begin
      pix_valid <= 1'b1;
      pix_data  <= buf_px;
    end else begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end
  end

  assign dbg_state      = state;
  assign dbg_line_valid = line_valid;

endmodule

// File: tb/tb_soc_system_sprite_line_fetch.sv
module tb_soc_system_sprite_line_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_line = '0;
  logic [10:0] sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic [10:0] hcount = '0;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        busy;
  logic [1:0]  dbg_state;
  logic        dbg_line_valid;

  soc_system_sprite_line_fetch_if #(.ADDR_W(10), .DATA_W(16)) rom_if ();

  soc_system_sprite_line_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .line_start     (line_start),
    .next_line      (next_line),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
    .hcount         (hcount),
    .rom            (rom_if),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .busy           (busy),
    .dbg_state      (dbg_state),
    .dbg_line_valid (dbg_line_valid)
  );

  // ROM model: registered read, data one cycle after the address.
  logic [15:0] rom_mem [1024];
  always @(posedge clk) begin
    if (rom_if.rom_clken) rom_if.rom_readdata <= rom_mem[rom_if.rom_address];
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  logic [9:0]  addr_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [16:0] exp_pix(input int h, input int x, input int base, input bit fetched);
    int off;
    off = h - x;
    if (fetched && off >= 0 && off < 32 && rom_mem[base + off] != 16'hF81F)
      return {1'b1, rom_mem[base + off]};
    return 17'h0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int nl, input int sy, input int sx, input bit en);
    next_line  = 10'(nl);
    sprite_y   = 10'(sy);
    sprite_x   = 11'(sx);
    enable     = en;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic push_addrs(input int base);
    for (int k = 0; k < 32; k++) addr_q.push_back(10'(base + k));
  endtask

  // Follows a fetch from the first cycle after line_start until busy falls.
  task automatic watch_fetch(input bit expect_fetch, input string name);
    int busy_cycles;
    int guard;
    logic [9:0] ea;
    busy_cycles = 0;
    guard = 0;
    while (guard < 60) begin
      if (rom_if.rom_chipselect) begin
        n_vec++;
        if (addr_q.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected rom access addr=%0d want none", name, rom_if.rom_address);
        end else begin
          ea = addr_q.pop_front();
          if (rom_if.rom_address !== ea) begin
            n_err++;
            $display("FAIL %s rom_address got %0d want %0d", name, rom_if.rom_address, ea);
          end
        end
      end
      if (rom_if.rom_clken !== rom_if.rom_chipselect) begin
        n_err++;
        $display("FAIL %s rom_clken got %0b want %0b", name, rom_if.rom_clken, rom_if.rom_chipselect);
      end
      if (busy && pix_valid) begin
        n_err++;
        $display("FAIL %s pix_valid during fetch got 1 want 0", name);
      end
      if (!busy) break;
      busy_cycles++;
      tick();
      guard++;
    end
    n_vec++;
    if (guard >= 60) begin
      n_err++;
      $display("FAIL %s busy timeout got >=60 cycles want 33", name);
    end
    n_vec++;
    if (busy_cycles != (expect_fetch ? 33 : 0)) begin
      n_err++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cycles, expect_fetch ? 33 : 0);
    end
    n_vec++;
    if (addr_q.size() != 0) begin
      n_err++;
      $display("FAIL %s missing rom accesses got %0d left want 0", name, addr_q.size());
      addr_q.delete();
    end
    n_vec++;
    if (dbg_line_valid !== expect_fetch) begin
      n_err++;
      $display("FAIL %s line_valid got %0b want %0b", name, dbg_line_valid, expect_fetch);
    end
  endtask

  // Sweeps hcount one column per cycle; output for column h is compared
  // after hcount has already moved on, so a combinational path is caught.
  task automatic sweep(input int lo, input int hi, input int x, input int base,
                       input bit fetched, input string name, output int n_on);
    logic [16:0] e;
    n_on = 0;
    hcount = 11'(lo);
    exp_q.push_back(exp_pix(lo, x, base, fetched));
    for (int h = lo; h <= hi; h++) begin
      tick();
      if (h < hi) begin
        hcount = 11'(h + 1);
        exp_q.push_back(exp_pix(h + 1, x, base, fetched));
      end
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({pix_valid, pix_data} !== e) begin
        n_err++;
        $display("FAIL %s hcount=%0d got v=%0b d=%h want v=%0b d=%h",
                 name, h, pix_valid, pix_data, e[16], e[15:0]);
      end
      if (pix_valid) n_on++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_vec++;
    if ({rom_if.rom_address, rom_if.rom_chipselect, rom_if.rom_clken, pix_valid, pix_data, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got addr=%0d cs=%0b ce=%0b pv=%0b pd=%h busy=%0b want all 0",
               rom_if.rom_address, rom_if.rom_chipselect, rom_if.rom_clken, pix_valid, pix_data, busy);
    end
    n_vec++;
    if (dbg_state !== 2'd0 || dbg_line_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got state=%0d lv=%0b want 0 0", dbg_state, dbg_line_valid);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    hcount = 11'd0;
    push_addrs(160);
    start_line(105, 100, 200, 1'b1);
    watch_fetch(1'b1, "fetch_row5");
  endtask

  task automatic test_pixels();
    int n_on;
    sprite_x = 11'd50;  // must not move the sprite until the next line_start
    sweep(190, 240, 200, 160, 1'b1, "pixels_row5", n_on);
    n_vec++;
    if (n_on != 32) begin
      n_err++;
      $display("FAIL pixels_count got %0d want 32", n_on);
    end
  endtask

  task automatic test_key();
    int n_on;
    rom_mem[7*32 + 5] = 16'hF81F;
    push_addrs(224);
    start_line(107, 100, 300, 1'b1);
    watch_fetch(1'b1, "key_fetch");
    sweep(295, 340, 300, 224, 1'b1, "key_pixels", n_on);
    n_vec++;
    if (n_on != 31) begin
      n_err++;
      $display("FAIL key_count got %0d want 31", n_on);
    end
    rom_mem[7*32 + 5] = 16'(7*32 + 5);
  endtask

  task automatic test_row_bounds();
    int n_on;
    start_line(99, 100, 200, 1'b1);
    watch_fetch(1'b0, "row_minus1");
    sweep(195, 235, 200, 0, 1'b0, "row_minus1_pix", n_on);
    start_line(132, 100, 200, 1'b1);
    watch_fetch(1'b0, "row_32");
    sweep(195, 235, 200, 0, 1'b0, "row_32_pix", n_on);
    start_line(105, 100, 200, 1'b0);
    watch_fetch(1'b0, "disabled");
    // last row of the sprite, reaching the top of the ROM
    push_addrs(992);
    start_line(131, 100, 620, 1'b1);
    watch_fetch(1'b1, "row_31");
    sweep(615, 639, 620, 992, 1'b1, "row_31_pix", n_on);
  endtask

  task automatic test_back_to_back();
    int n_on;
    hcount = 11'd210;
    for (int k = 0; k < 10; k++) addr_q.push_back(10'(160 + k));
    start_line(105, 100, 200, 1'b1);
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (rom_if.rom_chipselect !== 1'b1 || rom_if.rom_address !== addr_q.pop_front()) begin
        n_err++;
        $display("FAIL abort_first cycle=%0d got cs=%0b addr=%0d want cs=1 addr=%0d",
                 k, rom_if.rom_chipselect, rom_if.rom_address, 160 + k);
      end
      n_vec++;
      if (pix_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_pix cycle=%0d got 1 want 0", k);
      end
      if (k < 9) tick();
    end
    push_addrs(320);
    start_line(110, 100, 200, 1'b1);
    watch_fetch(1'b1, "abort_restart");
    sweep(198, 234, 200, 320, 1'b1, "abort_pixels", n_on);
  endtask

  task automatic test_reset_mid();
    int n_on;
    hcount = 11'd205;
    tick();
    tick();
    n_vec++;
    if ({pix_valid, pix_data} !== {1'b1, 16'(325)}) begin
      n_err++;
      $display("FAIL pre_reset_pix got v=%0b d=%h want v=1 d=%h", pix_valid, pix_data, 16'(325));
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (pix_valid !== 1'b0 || pix_data !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset_pix got v=%0b d=%h want 0 0", pix_valid, pix_data);
    end
    tick();
    reset = 1'b0;
    start_line(105, 100, 200, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    n_vec++;
    if (busy !== 1'b1 || rom_if.rom_chipselect !== 1'b1) begin
      n_err++;
      $display("FAIL mid_fetch got busy=%0b cs=%0b want 1 1", busy, rom_if.rom_chipselect);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({rom_if.rom_chipselect, rom_if.rom_clken, busy, pix_valid} !== 4'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset_fetch got cs=%0b ce=%0b busy=%0b pv=%0b state=%0d want 0",
               rom_if.rom_chipselect, rom_if.rom_clken, busy, pix_valid, dbg_state);
    end
    tick();
    reset = 1'b0;
    tick();
    push_addrs(192);
    start_line(106, 100, 400, 1'b1);
    watch_fetch(1'b1, "post_reset_fetch");
    sweep(396, 436, 400, 192, 1'b1, "post_reset_pix", n_on);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int k = 0; k < 1024; k++) rom_mem[k] = 16'(k);
    test_reset();
    test_fetch();
    test_pixels();
    test_key();
    test_row_bounds();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
